guess_scorer: RTL and testbench



---
 rtl/bc_pkg.sv | 18 +
 rtl/digit_matcher.sv | 17 +
 rtl/guess_scorer.sv | 128 ++++++++++++
 tb/tb_guess_scorer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// bc_pkg: shared types, constants and helpers for the bulls-and-cows scorer.
package bc_pkg;
   typedef logic [3:0] digit_t;
   localparam int NUM_DIGITS = 4;
   localparam int MAX_TURNS = 6;
   localparam digit_t BLANK_DIGIT = 4'hF;
   typedef struct {
      digit_t     guess [NUM_DIGITS];
      logic [2:0] a;
      logic [2:0] b;
      logic       valid;
   } hist_entry_t;
   typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} scorer_state_t;
   // Blank, marker and any other non-decimal code never take part in a match.
   function automatic logic digit_ok(digit_t d);
      return d <= 4'd9;
   endfunction
endpackage

// File: rtl/digit_matcher.sv
// digit_matcher: classifies one guess digit against the secret as an exact or a misplaced hit.
module digit_matcher
   import bc_pkg::*;
(
   input  digit_t                  g_i,
   input  logic [1:0]              pos_i,
   input  digit_t [NUM_DIGITS-1:0] secret_i,
   output logic                    hit_a,
   output logic                    hit_b
);
   logic [NUM_DIGITS-1:0] eq;
   always_comb begin
      for (int j = 0; j < NUM_DIGITS; j++) eq[j] = digit_ok(g_i) && secret_i[j] == g_i;
   end
   assign hit_a = eq[pos_i];
   assign hit_b = !hit_a && |eq;
endmodule

// File: rtl/guess_scorer.sv
// guess_scorer: multi-cycle bulls-and-cows compare of the latched secret/guess with a per-turn history.
module guess_scorer
   import bc_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    clear,
   input  logic                    start,
   input  digit_t [NUM_DIGITS-1:0] Secret,
   input  digit_t [NUM_DIGITS-1:0] Guess,
   input  logic [2:0]              turn_count,
   output logic                    busy,
   output logic                    done,
   output logic [2:0]              Count_A,
   output logic [2:0]              Count_B,
   output logic                    all_match,
   input  logic [2:0]              hist_rd_idx,
   output digit_t [NUM_DIGITS-1:0] hist_guess,
   output logic [2:0]              hist_a,
   output logic [2:0]              hist_b,
   output logic                    hist_valid,
   output logic [2:0]              hist_count
);
   scorer_state_t           state_q, state_d;
   digit_t [NUM_DIGITS-1:0] sec_q, sec_d, gss_q, gss_d;
   logic [1:0]              idx_q, idx_d;
   logic [2:0]              acc_a_q, acc_a_d, acc_b_q, acc_b_d;
   logic [2:0]              cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, hist_count_q;
   hist_entry_t             hist_q [MAX_TURNS];
   hist_entry_t             rd;
   logic                    hit_a, hit_b, wr_en, rd_ok;

   digit_matcher u_match (
      .g_i      (gss_q[idx_q]),
      .pos_i    (idx_q),
      .secret_i (sec_q),
      .hit_a    (hit_a),
      .hit_b    (hit_b)
   );

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      gss_d   = gss_q;
      idx_d   = idx_q;
      acc_a_d = acc_a_q;
      acc_b_d = acc_b_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      case (state_q)
         S_IDLE: if (start) begin
            sec_d   = Secret;
            gss_d   = Guess;
            acc_a_d = '0;
            acc_b_d = '0;
            idx_d   = 2'd3;
            state_d = S_CMP;
         end
         S_CMP: begin
            acc_a_d = acc_a_q + 3'(hit_a);
            acc_b_d = acc_b_q + 3'(hit_b);
            idx_d   = idx_q - 2'd1;
            // Publish the counts on the way into S_DONE so they are valid alongside done.
            if (idx_q == 2'd0) begin
               state_d = S_DONE;
               cnt_a_d = acc_a_d;
               cnt_b_d = acc_b_d;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_en = state_q == S_DONE && int'(turn_count) < MAX_TURNS;

   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         state_q      <= S_IDLE;
         sec_q        <= '0;
         gss_q        <= '0;
         idx_q        <= '0;
         acc_a_q      <= '0;
         acc_b_q      <= '0;
         cnt_a_q      <= '0;
         cnt_b_q      <= '0;
         hist_count_q <= '0;
         for (int i = 0; i < MAX_TURNS; i++) begin
            hist_q[i].a     <= '0;
            hist_q[i].b     <= '0;
            hist_q[i].valid <= 1'b0;
            for (int j = 0; j < NUM_DIGITS; j++) hist_q[i].guess[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         gss_q   <= gss_d;
         idx_q   <= idx_d;
         acc_a_q <= acc_a_d;
         acc_b_q <= acc_b_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         if (wr_en) begin
            for (int j = 0; j < NUM_DIGITS; j++) hist_q[turn_count].guess[j] <= gss_q[j];
            hist_q[turn_count].a     <= cnt_a_q;
            hist_q[turn_count].b     <= cnt_b_q;
            hist_q[turn_count].valid <= 1'b1;
            if (!hist_q[turn_count].valid) hist_count_q <= hist_count_q + 3'd1;
         end
      end
   end

   assign rd_ok = int'(hist_rd_idx) < MAX_TURNS;
   assign rd    = hist_q[rd_ok ? hist_rd_idx : 3'd0];

   always_comb begin
      for (int j = 0; j < NUM_DIGITS; j++) hist_guess[j] = rd_ok ? rd.guess[j] : '0;
   end

   assign hist_a     = rd_ok ? rd.a : '0;
   assign hist_b     = rd_ok ? rd.b : '0;
   assign hist_valid = rd_ok && rd.valid;
   assign hist_count = hist_count_q;
   assign busy       = state_q != S_IDLE;
   assign done       = state_q == S_DONE;
   assign Count_A    = cnt_a_q;
   assign Count_B    = cnt_b_q;
   assign all_match  = cnt_a_q == 3'd4;
endmodule

// File: tb/tb_guess_scorer.sv
// tb_guess_scorer: scoreboard bench; expected counts are queued at start and retired on done.
module tb_guess_scorer;
   logic        CLK = 1'b0;
   logic        RESET, clear, start, busy, done, all_match, hist_valid;
   logic [15:0] Secret, Guess, hist_guess;
   logic [2:0]  turn_count, hist_rd_idx, Count_A, Count_B, hist_a, hist_b, hist_count;
   logic [5:0]  sb_q [$];
   logic [5:0]  exp_ab;
   logic [15:0] rs, rg;
   int          errors = 0, checks = 0, dones = 0;

   always #5 CLK = ~CLK;

   guess_scorer dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .clear       (clear),
      .start       (start),
      .Secret      (Secret),
      .Guess       (Guess),
      .turn_count  (turn_count),
      .busy        (busy),
      .done        (done),
      .Count_A     (Count_A),
      .Count_B     (Count_B),
      .all_match   (all_match),
      .hist_rd_idx (hist_rd_idx),
      .hist_guess  (hist_guess),
      .hist_a      (hist_a),
      .hist_b      (hist_b),
      .hist_valid  (hist_valid),
      .hist_count  (hist_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference scoring: exact hit first, otherwise any other position holding the same valid digit.
   function automatic logic [5:0] model(input logic [15:0] s, input logic [15:0] g);
      int a = 0, b = 0;
      logic [3:0] gd;
      for (int i = 0; i < 4; i++) begin
         gd = g[i*4+:4];
         if (gd > 4'd9) continue;
         if (gd == s[i*4+:4]) a++;
         else for (int j = 0; j < 4; j++) if (j != i && s[j*4+:4] == gd) begin
            b++;
            break;
         end
      end
      return {3'(a), 3'(b)};
   endfunction

   function automatic logic [15:0] rnd_code();
      logic [15:0] c;
      int v;
      for (int i = 0; i < 4; i++) begin
         v = $urandom_range(0, 6);
         c[i*4+:4] = v == 6 ? 4'hF : 4'(v);
      end
      return c;
   endfunction

   always @(negedge CLK) begin
      if (done) begin
         dones++;
         if (sb_q.size() == 0) check("spurious_done", 1, 0);
         else begin
            exp_ab = sb_q.pop_front();
            check("count_a", Count_A, exp_ab[5:3]);
            check("count_b", Count_B, exp_ab[2:0]);
            check("all_match", all_match, exp_ab[5:3] == 3'd4);
         end
      end
   end

   task automatic turn(input logic [15:0] s, input logic [15:0] g, input logic [2:0] tc,
                       input logic dbl, input logic [5:0] e);
      int d0;
      @(posedge CLK); #1;
      Secret = s; Guess = g; turn_count = tc; start = 1'b1;
      sb_q.push_back(e);
      d0 = dones;
      @(posedge CLK); #1;
      start = 1'b0; Secret = 16'($urandom); Guess = 16'($urandom);
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) begin @(posedge CLK); #1; end
         start = dbl && k == 2;
         @(negedge CLK);
         check("busy", busy, 1);
         check("done_timing", done, k == 5);
      end
      @(posedge CLK); #1;
      start = 1'b0;
      @(negedge CLK);
      check("busy_after", busy, 0);
      check("done_count", dones - d0, 1);
      if (tc < 3'd6) begin
         hist_rd_idx = tc; #1;
         check("hist_valid", hist_valid, 1);
         check("hist_guess", hist_guess, g);
         check("hist_a", hist_a, e[5:3]);
         check("hist_b", hist_b, e[2:0]);
      end
   endtask

   initial begin
      RESET = 1'b1; clear = 1'b0; start = 1'b0;
      Secret = '0; Guess = '0; turn_count = '0; hist_rd_idx = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count_a", Count_A, 0);
      check("rst_count_b", Count_B, 0);
      check("rst_all_match", all_match, 0);
      check("rst_hist_count", hist_count, 0);
      for (int i = 0; i < 6; i++) begin
         hist_rd_idx = 3'(i); #1;
         check("rst_hist_valid", hist_valid, 0);
         check("rst_hist_guess", hist_guess, 0);
      end
      @(posedge CLK); #1;
      RESET = 1'b0;

      turn(16'h1234, 16'h1234, 3'd0, 1'b0, {3'd4, 3'd0});
      check("hist_count_1", hist_count, 1);
      turn(16'h1234, 16'h4321, 3'd1, 1'b0, {3'd0, 3'd4});
      turn(16'h1234, 16'h1243, 3'd2, 1'b1, {3'd2, 3'd2});
      turn(16'h1234, 16'h5678, 3'd3, 1'b0, {3'd0, 3'd0});
      turn(16'h12F4, 16'hF2F9, 3'd4, 1'b0, {3'd1, 3'd0});
      turn(16'hFFFF, 16'hFFFF, 3'd5, 1'b0, {3'd0, 3'd0});
      check("hist_count_6", hist_count, 6);
      for (int i = 0; i < 6; i++) begin
         hist_rd_idx = 3'(i); #1;
         check("hist_all_valid", hist_valid, 1);
      end

      turn(16'h9876, 16'h6789, 3'd6, 1'b0, {3'd0, 3'd4});
      check("hist_count_sat", hist_count, 6);
      hist_rd_idx = 3'd0; #1;
      check("hist0_kept", hist_guess, 16'h1234);
      turn(16'h1111, 16'h1000, 3'd3, 1'b0, {3'd1, 3'd0});
      check("hist_count_rewrite", hist_count, 6);
      hist_rd_idx = 3'd7; #1;
      check("hist_oob_valid", hist_valid, 0);
      check("hist_oob_guess", hist_guess, 0);
      check("hist_oob_a", hist_a, 0);
      hist_rd_idx = 3'd6; #1;
      check("hist_oob6_valid", hist_valid, 0);

      // Abort a compare with clear in cycle 3.
      @(posedge CLK); #1;
      Secret = 16'h1234; Guess = 16'h1234; turn_count = 3'd0; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      clear = 1'b1;
      @(posedge CLK); #1;
      clear = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         check("clr_busy", busy, 0);
         check("clr_done", done, 0);
      end
      check("clr_count_a", Count_A, 0);
      check("clr_count_b", Count_B, 0);
      check("clr_hist_count", hist_count, 0);
      hist_rd_idx = 3'd0; #1;
      check("clr_hist_valid", hist_valid, 0);

      @(posedge CLK); #1;
      clear = 1'b1; start = 1'b1;
      @(posedge CLK); #1;
      clear = 1'b0; start = 1'b0;
      repeat (6) begin
         @(negedge CLK);
         check("clr_start_busy", busy, 0);
         check("clr_start_done", done, 0);
      end

      for (int n = 0; n < 10; n++) begin
         rs = rnd_code();
         rg = (n % 3 == 0) ? {rs[7:0], rs[15:8]} : rnd_code();
         turn(rs, rg, 3'(n % 6), 1'(n % 2), model(rs, rg));
      end
      check("hist_count_final", hist_count, 6);

      repeat (3) @(posedge CLK);
      check("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
